quantum_preempt_ctrl: RTL and testbench

- Consumer side of the scheduler quantum pulse.
- Latches a quantum expiry and waits for the core to be preemptible at an instruction boundary.
- Issues a one-cycle trap redirect, saves the interrupted PC and tracks handler residency.
- On handler return, issues a restart pulse back to the quantum counter.

---
 rtl/quantum_pkg.sv | 15 +
 rtl/preempt_wdog.sv | 44 ++++
 rtl/quantum_preempt_ctrl.sv | 119 +++++++++++
 tb/tb_quantum_preempt_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/quantum_pkg.sv
// Shared types and defaults for the quantum preemption controller.
// Holds the FSM state enum and default widths / trap vector.
package quantum_pkg;

   localparam int          PC_W_DEF        = 32;
   localparam int          MISS_W_DEF      = 4;
   localparam logic [31:0] TRAP_VECTOR_DEF = 32'h0000_0100;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PENDING,
      ST_HANDLER
   } state_e;

endpackage

// File: rtl/preempt_wdog.sv
// Handler watchdog: counts cycles while active_i, sets a sticky fault
// when the count reaches WDOG_CYCLES. Ports: clk, reset, active_i, fault_o.
module preempt_wdog #(
   parameter int WDOG_CYCLES = 256
) (
   input  logic clk,
   input  logic reset,
   input  logic active_i,
   output logic fault_o
);

   localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WDOG_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fault_q, fault_d;

   always_comb begin
      cnt_d   = cnt_q;
      fault_d = fault_q;
      if (!active_i) begin
         cnt_d = '0;
      end else if (cnt_q != LIMIT) begin
         cnt_d = cnt_q + 1'b1;
      end
      // Sticky: only reset clears it.
      if (active_i && cnt_d == LIMIT) begin
         fault_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   assign fault_o = fault_q;

endmodule

// File: rtl/quantum_preempt_ctrl.sv
// Quantum expiry consumer: waits for a preemptible boundary, issues a
// trap redirect, saves EPC, tracks the handler and restarts the quantum.
// Ports: clk, reset (async, high), quantum_over, irq_enable,
//   instr_boundary, pc_next, trap_return -> take_trap, trap_vector, epc,
//   in_handler, quantum_restart, missed_quanta, wdog_fault.
// Macro QUANTUM_WDOG_EN builds the handler watchdog (preempt_wdog).
module quantum_preempt_ctrl
   import quantum_pkg::*;
#(
   parameter int              PC_W        = PC_W_DEF,
   parameter logic [PC_W-1:0] TRAP_VECTOR = PC_W'(TRAP_VECTOR_DEF),
   parameter int              MISS_W      = MISS_W_DEF,
   parameter int              WDOG_CYCLES = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              quantum_over,
   input  logic              irq_enable,
   input  logic              instr_boundary,
   input  logic [PC_W-1:0]   pc_next,
   input  logic              trap_return,
   output logic              take_trap,
   output logic [PC_W-1:0]   trap_vector,
   output logic [PC_W-1:0]   epc,
   output logic              in_handler,
   output logic              quantum_restart,
   output logic [MISS_W-1:0] missed_quanta,
   output logic              wdog_fault
);

   state_e            state_q, state_d;
   logic [PC_W-1:0]   epc_q, epc_d;
   logic [MISS_W-1:0] miss_q, miss_d;
   logic [MISS_W-1:0] miss_inc;
   logic              take_q, take_d;
   logic              inh_q, inh_d;
   logic              rst_q, rst_d;

   assign miss_inc = (&miss_q) ? miss_q : miss_q + 1'b1;

   always_comb begin
      state_d = state_q;
      epc_d   = epc_q;
      miss_d  = miss_q;
      take_d  = 1'b0;
      rst_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // Preemption inputs are not looked at on the expiry cycle.
            if (quantum_over) begin
               state_d = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (quantum_over) begin
               miss_d = miss_inc;
            end
            if (irq_enable && instr_boundary) begin
               state_d = ST_HANDLER;
               take_d  = 1'b1;
               epc_d   = pc_next;
            end
         end
         ST_HANDLER: begin
            // Return wins: the restart resets the counter anyway.
            if (trap_return) begin
               state_d = ST_IDLE;
               rst_d   = 1'b1;
               miss_d  = '0;
            end else if (quantum_over) begin
               miss_d = miss_inc;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      inh_d = (state_d == ST_HANDLER);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         epc_q   <= '0;
         miss_q  <= '0;
         take_q  <= 1'b0;
         inh_q   <= 1'b0;
         rst_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         epc_q   <= epc_d;
         miss_q  <= miss_d;
         take_q  <= take_d;
         inh_q   <= inh_d;
         rst_q   <= rst_d;
      end
   end

   assign take_trap       = take_q;
   assign trap_vector     = TRAP_VECTOR;
   assign epc             = epc_q;
   assign in_handler      = inh_q;
   assign quantum_restart = rst_q;
   assign missed_quanta   = miss_q;

`ifdef QUANTUM_WDOG_EN
   preempt_wdog #(
      .WDOG_CYCLES(WDOG_CYCLES)
   ) u_wdog (
      .clk     (clk),
      .reset   (reset),
      .active_i(inh_q),
      .fault_o (wdog_fault)
   );
`else
   assign wdog_fault = 1'b0;
`endif

endmodule

// File: tb/tb_quantum_preempt_ctrl.sv
// Randomized and directed bench for quantum_preempt_ctrl with an
// event-level reference model.
module tb_quantum_preempt_ctrl;

   localparam int PC_W = 32;
   localparam int MISS_W = 4;
   localparam int WDOG = 8;
   localparam logic [31:0] TV = 32'h0000_0100;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic quantum_over = 1'b0;
   logic irq_enable = 1'b0;
   logic instr_boundary = 1'b0;
   logic [PC_W-1:0] pc_next = '0;
   logic trap_return = 1'b0;
   logic take_trap;
   logic [PC_W-1:0] trap_vector;
   logic [PC_W-1:0] epc;
   logic in_handler;
   logic quantum_restart;
   logic [MISS_W-1:0] missed_quanta;
   logic wdog_fault;

   int n_vec = 0;
   int n_bad = 0;

   // model: outstanding expiry, handler residency, counters
   bit m_pend, m_inh, m_take, m_rst, m_fault;
   int m_miss, m_wcnt;
   logic [31:0] m_epc;

   always #5 clk = ~clk;

   quantum_preempt_ctrl #(
      .PC_W(PC_W),
      .TRAP_VECTOR(TV),
      .MISS_W(MISS_W),
      .WDOG_CYCLES(WDOG)
   ) dut (
      .clk(clk),
      .reset(reset),
      .quantum_over(quantum_over),
      .irq_enable(irq_enable),
      .instr_boundary(instr_boundary),
      .pc_next(pc_next),
      .trap_return(trap_return),
      .take_trap(take_trap),
      .trap_vector(trap_vector),
      .epc(epc),
      .in_handler(in_handler),
      .quantum_restart(quantum_restart),
      .missed_quanta(missed_quanta),
      .wdog_fault(wdog_fault)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   function automatic void m_reset();
      m_pend = 0; m_inh = 0; m_take = 0; m_rst = 0;
      m_fault = 0; m_miss = 0; m_wcnt = 0; m_epc = '0;
   endfunction

   function automatic int sat(input int v);
      int lim = (1 << MISS_W) - 1;
      return (v + 1 > lim) ? lim : v + 1;
   endfunction

   function automatic void m_step(input bit qo, ie, ib,
                                  input logic [31:0] pc, input bit tr);
      // watchdog: cycles spent inside the handler before this edge
      if (m_inh) begin
         m_wcnt++;
`ifdef QUANTUM_WDOG_EN
         if (m_wcnt >= WDOG) m_fault = 1;
`endif
      end else begin
         m_wcnt = 0;
      end
      m_take = 0;
      m_rst = 0;
      if (m_inh) begin
         if (tr) begin
            m_inh = 0; m_rst = 1; m_miss = 0;
         end else if (qo) begin
            m_miss = sat(m_miss);
         end
      end else if (m_pend) begin
         if (qo) m_miss = sat(m_miss);
         if (ie && ib) begin
            m_pend = 0; m_inh = 1; m_take = 1; m_epc = pc;
         end
      end else if (qo) begin
         m_pend = 1;
      end
   endfunction

   task automatic check_all();
      chk("take_trap", 32'(take_trap), 32'(m_take));
      chk("in_handler", 32'(in_handler), 32'(m_inh));
      chk("restart", 32'(quantum_restart), 32'(m_rst));
      chk("epc", epc, m_epc);
      chk("missed", 32'(missed_quanta), 32'(m_miss));
      chk("wdog", 32'(wdog_fault), 32'(m_fault));
      chk("vector", trap_vector, TV);
   endtask

   task automatic cyc(input bit qo, ie, ib, input logic [31:0] pc,
                      input bit tr);
      @(negedge clk);
      quantum_over = qo;
      irq_enable = ie;
      instr_boundary = ib;
      pc_next = pc;
      trap_return = tr;
      @(posedge clk);
      m_step(qo, ie, ib, pc, tr);
      #1;
      check_all();
   endtask

   task automatic async_reset();
      @(negedge clk);
      quantum_over = 0; irq_enable = 0; instr_boundary = 0;
      trap_return = 0;
      #2 reset = 1'b1;
      #1;
      m_reset();
      check_all();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      m_reset();
      #1;
      check_all();
      @(negedge clk);
      reset = 1'b0;

      // basic preemption: expiry at cycle 5, boundary at cycle 6
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, '0, 0);
      cyc(1, 1, 1, 32'h80, 0);
      cyc(0, 1, 1, 32'h40, 0);
      chk("basic_take", 32'(take_trap), 32'd1);
      chk("basic_epc", epc, 32'h40);
      cyc(0, 0, 0, '0, 0);
      cyc(0, 0, 0, '0, 1);

      // blocked preemption with three extra expiries
      cyc(1, 0, 0, '0, 0);
      for (int i = 0; i < 20; i++)
         cyc(i % 7 == 3, 0, 1, 32'h1000 + i, 0);
      chk("blocked_miss", 32'(missed_quanta), 32'd3);
      cyc(0, 1, 1, 32'h2468, 0);
      chk("blocked_take", 32'(take_trap), 32'd1);

      // saturation inside the handler, then return
      for (int i = 0; i < 20; i++) cyc(1, 1, 1, 32'h5, 0);
      chk("sat_miss", 32'(missed_quanta), 32'd15);
      chk("sat_nottake", 32'(take_trap), 32'd0);
      cyc(0, 0, 0, '0, 1);
      chk("ret_restart", 32'(quantum_restart), 32'd1);
      chk("ret_miss", 32'(missed_quanta), 32'd0);
      cyc(0, 1, 1, '0, 0);
      chk("ret_idle", 32'(take_trap), 32'd0);

      // same-cycle trap_return and quantum_over
      cyc(1, 0, 0, '0, 0);
      cyc(0, 1, 1, 32'h77, 0);
      cyc(1, 0, 0, '0, 1);
      cyc(0, 1, 1, 32'h99, 0);
      chk("prio_nopend", 32'(take_trap), 32'd0);

      // async reset mid-handler
      cyc(1, 0, 0, '0, 0);
      cyc(0, 1, 1, 32'h3c, 0);
      cyc(0, 0, 0, '0, 0);
      async_reset();
      cyc(0, 0, 0, '0, 0);
      chk("rst_norestart", 32'(quantum_restart), 32'd0);

      // long handler residency (watchdog when built)
      cyc(1, 0, 0, '0, 0);
      cyc(0, 1, 1, 32'h10, 0);
      for (int i = 0; i < 10; i++) cyc(0, 0, 0, '0, 0);
      cyc(0, 0, 0, '0, 1);
      cyc(0, 0, 0, '0, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            async_reset();
         end else begin
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom,
                $urandom_range(0, 9) == 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
